// File: rtl/ir_sequencer.sv
// Instruction register and T-state sequencer: latches the fetched word at T1,
// strobes the PC, forms the microcode address and drives immediates onto the bus.
module ir_sequencer #(
    parameter int TSTATE_BITS = 3,
    parameter int FETCH_STEPS = 2
) (
    input  logic                     clk,
    input  logic                     reset_bar,
    inout  wire  [15:0]              bus,
    input  logic                     rt_bar,
    input  logic                     halt_bar,
    input  logic                     iol_en_bar,
    input  logic                     ioh_en_bar,
    output logic [15:0]              ir,
    output logic [TSTATE_BITS-1:0]   tstate,
    output logic [8+TSTATE_BITS-1:0] uaddr,
    output logic                     fetch,
    output logic                     pc_inc
);

    localparam logic [TSTATE_BITS-1:0] FETCH_LAST = TSTATE_BITS'(FETCH_STEPS - 1);
    localparam logic [TSTATE_BITS-1:0] FETCH_END  = TSTATE_BITS'(FETCH_STEPS);
    localparam logic [TSTATE_BITS-1:0] STEP_ONE   = TSTATE_BITS'(1);

    logic        load_step;
    logic        drive_en;
    logic [15:0] drive_val;

    // The last fetch step is the one that samples the bus and bumps the PC.
    assign load_step = (tstate == FETCH_LAST);

    always_comb begin
        uaddr  = {ir[15:8], tstate};
        fetch  = (tstate < FETCH_END);
        pc_inc = load_step && halt_bar;
    end

    // iol wins when both enables are low, so the block never fights itself.
    always_comb begin
        drive_en  = !load_step && (!iol_en_bar || !ioh_en_bar);
        drive_val = !iol_en_bar ? {8'h00, ir[7:0]} : {8'hFF, ir[7:0]};
    end

    assign bus = drive_en ? drive_val : 16'hzzzz;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            tstate <= '0;
            ir     <= 16'h0000;
        end else if (halt_bar) begin
            if (load_step) begin
                ir <= bus;
            end
            if (!rt_bar && (tstate >= FETCH_END)) begin
                tstate <= '0;
            end else begin
                tstate <= tstate + STEP_ONE;
            end
        end
    end

endmodule
